// File: rtl/scoreboard_register_file_if.sv
// rtl/scoreboard_register_file_if.sv - read/write/reserve bus bundle for the scoreboard register file
`timescale 1ns/1ps

interface scoreboard_register_file_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] read1Addr;
    logic [ADDR_WIDTH-1:0] read2Addr;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic                  read1Busy;
    logic                  read2Busy;
    logic                  we;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  reserveEn;
    logic [ADDR_WIDTH-1:0] reserveAddr;
    logic [ADDR_WIDTH:0]   busyCount;

    modport master (
        output read1Addr, read2Addr, we, writeAddr, writeData, reserveEn, reserveAddr,
        input  readData1, readData2, read1Busy, read2Busy, busyCount
    );

    modport slave (
        input  read1Addr, read2Addr, we, writeAddr, writeData, reserveEn, reserveAddr,
        output readData1, readData2, read1Busy, read2Busy, busyCount
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - 2R/1W register file with per-register busy scoreboard
`timescale 1ns/1ps

module scoreboard_register_file #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    scoreboard_register_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic                  write_ok;
    logic                  reserve_ok;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign write_ok   = bus.we && !is_zero_reg(bus.writeAddr);
    assign reserve_ok = bus.reserveEn && !is_zero_reg(bus.reserveAddr);

    // Reserve is applied after the write-clear so a same-edge new producer keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (write_ok) begin
            busy_next[bus.writeAddr] = 1'b0;
        end
        if (reserve_ok) begin
            busy_next[bus.reserveAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (write_ok) begin
                regs[bus.writeAddr] <= bus.writeData;
            end
            busy <= busy_next;
        end
    end

    always_comb begin
        bus.readData1 = regs[bus.read1Addr];
        bus.read1Busy = busy[bus.read1Addr];
        if (is_zero_reg(bus.read1Addr)) begin
            bus.readData1 = '0;
            bus.read1Busy = 1'b0;
        end else if ((BYPASS != 0) && bus.we && (bus.writeAddr == bus.read1Addr)) begin
            bus.readData1 = bus.writeData;
            bus.read1Busy = 1'b0;
        end
    end

    always_comb begin
        bus.readData2 = regs[bus.read2Addr];
        bus.read2Busy = busy[bus.read2Addr];
        if (is_zero_reg(bus.read2Addr)) begin
            bus.readData2 = '0;
            bus.read2Busy = 1'b0;
        end else if ((BYPASS != 0) && bus.we && (bus.writeAddr == bus.read2Addr)) begin
            bus.readData2 = bus.writeData;
            bus.read2Busy = 1'b0;
        end
    end

    always_comb begin
        bus.busyCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.busyCount = bus.busyCount + {{ADDR_WIDTH{1'b0}}, busy[i]};
        end
    end
endmodule
